axi_lite_xbar_n: RTL

Parametrised 1-master / N-slave AXI4-Lite crossbar between the core's AXI arbiter and the memory and device slaves. It decodes both the read and write address channels against a per-slave base/mask map and registers the selected route. It holds that route until the response handshake completes, and flags device accesses for difftest skipping. One read and one write may be outstanding at the same time.

---
 rtl/axi_lite_pkg.sv | 18 +
 rtl/xbar_addr_decode.sv | 26 ++
 rtl/axi_lite_xbar_n.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite crossbar.
// XBAR_DECERR_EN adds the decode-error states to both FSMs.
package axi_lite_pkg;

    localparam int MAX_NSLV = 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

`ifdef XBAR_DECERR_EN
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP, W_ERR} w_state_e;
`else
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;
`endif

endpackage

// File: rtl/xbar_addr_decode.sv
// Combinational address decoder: one-hot hit on the lowest-index matching
// slave window, plus a flag for addresses that match no window.
module xbar_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int                      NSLV     = 3,
    parameter int                      ADDR_W   = 32,
    parameter logic [NSLV*ADDR_W-1:0]  SLV_BASE = '0,
    parameter logic [NSLV*ADDR_W-1:0]  SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NSLV-1:0]   hit,
    output logic              unmapped
);

    logic [NSLV-1:0] match;

    for (genvar gi = 0; gi < NSLV; gi++) begin : g_match
        assign match[gi] = ((addr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W]);
    end

    // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
    assign hit      = match & (~match + NSLV'(1));
    assign unmapped = ~|match;

endmodule

// File: rtl/axi_lite_xbar_n.sv
// 1-master / N-slave AXI4-Lite crossbar with independent read and write FSMs.
// Define XBAR_DECERR_EN to answer unmapped addresses with DECERR instead of routing to slave 0.
module axi_lite_xbar_n
    import axi_lite_pkg::*;
#(
    parameter int                      NSLV      = 3,
    parameter int                      ADDR_W    = 32,
    parameter int                      DATA_W    = 32,
    parameter logic [NSLV*ADDR_W-1:0]  SLV_BASE  = {32'h1000_0000, 32'h0200_0000, 32'h8000_0000},
    parameter logic [NSLV*ADDR_W-1:0]  SLV_MASK  = {32'hFFFF_F000, 32'hFFFF_0000, 32'hE000_0000},
    parameter logic [NSLV-1:0]         SKIP_MASK = '0
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic                       m_arvalid,
    output logic                       m_arready,
    input  logic [ADDR_W-1:0]          m_araddr,
    output logic                       m_rvalid,
    input  logic                       m_rready,
    output logic [DATA_W-1:0]          m_rdata,
    output logic [1:0]                 m_rresp,
    input  logic                       m_awvalid,
    output logic                       m_awready,
    input  logic [ADDR_W-1:0]          m_awaddr,
    input  logic                       m_wvalid,
    output logic                       m_wready,
    input  logic [DATA_W-1:0]          m_wdata,
    input  logic [DATA_W/8-1:0]        m_wstrb,
    output logic                       m_bvalid,
    input  logic                       m_bready,
    output logic [1:0]                 m_bresp,

    output logic [NSLV-1:0]            s_arvalid,
    input  logic [NSLV-1:0]            s_arready,
    output logic [NSLV*ADDR_W-1:0]     s_araddr,
    input  logic [NSLV-1:0]            s_rvalid,
    output logic [NSLV-1:0]            s_rready,
    input  logic [NSLV*DATA_W-1:0]     s_rdata,
    input  logic [NSLV*2-1:0]          s_rresp,
    output logic [NSLV-1:0]            s_awvalid,
    input  logic [NSLV-1:0]            s_awready,
    output logic [NSLV*ADDR_W-1:0]     s_awaddr,
    output logic [NSLV-1:0]            s_wvalid,
    input  logic [NSLV-1:0]            s_wready,
    output logic [NSLV*DATA_W-1:0]     s_wdata,
    output logic [NSLV*DATA_W/8-1:0]   s_wstrb,
    input  logic [NSLV-1:0]            s_bvalid,
    output logic [NSLV-1:0]            s_bready,
    input  logic [NSLV*2-1:0]          s_bresp,

    output logic                       diff_skip
);

    localparam int STRB_W = DATA_W / 8;

    r_state_e            r_state_q, r_state_d;
    logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
    logic [NSLV-1:0]     r_sel_q, r_sel_d;
    logic [NSLV-1:0]     ar_hit, ar_route;
    logic                ar_unmapped;
    logic                r_done, r_skip;

    w_state_e            w_state_q, w_state_d;
    logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]   w_strb_q, w_strb_d;
    logic [NSLV-1:0]     w_sel_q, w_sel_d;
    logic                aw_flag_q, aw_flag_d;
    logic                w_flag_q, w_flag_d;
    logic [NSLV-1:0]     aw_hit, aw_route;
    logic                aw_unmapped;
    logic                w_done, w_skip;
`ifdef XBAR_DECERR_EN
    logic                aw_err_q, aw_err_d;
`endif

    logic                diff_skip_q, diff_skip_d;

    xbar_addr_decode #(
        .NSLV     (NSLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_ar_decode (
        .addr     (m_araddr),
        .hit      (ar_hit),
        .unmapped (ar_unmapped)
    );

    xbar_addr_decode #(
        .NSLV     (NSLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_aw_decode (
        .addr     (m_awaddr),
        .hit      (aw_hit),
        .unmapped (aw_unmapped)
    );

`ifdef XBAR_DECERR_EN
    assign ar_route = ar_hit;
    assign aw_route = aw_hit;
`else
    // Unmapped traffic falls through to the default memory port.
    assign ar_route = ar_unmapped ? NSLV'(1) : ar_hit;
    assign aw_route = aw_unmapped ? NSLV'(1) : aw_hit;
`endif

    // Readys are held low while reset is asserted so they only rise once it releases.
    assign m_arready = !reset && (r_state_q == R_IDLE);
    assign m_awready = !reset && (w_state_q == W_IDLE) && !aw_flag_q;
    assign m_wready  = !reset && (w_state_q == W_IDLE) && !w_flag_q;

    always_comb begin
        m_rvalid = 1'b0;
        m_rdata  = '0;
        m_rresp  = OKAY;
        if (r_state_q == R_DATA) begin
            for (int i = 0; i < NSLV; i++) begin
                if (r_sel_q[i]) begin
                    m_rvalid = m_rvalid | s_rvalid[i];
                    m_rdata  = m_rdata | s_rdata[i*DATA_W +: DATA_W];
                    m_rresp  = m_rresp | s_rresp[i*2 +: 2];
                end
            end
        end
`ifdef XBAR_DECERR_EN
        if (r_state_q == R_ERR) begin
            m_rvalid = 1'b1;
            m_rresp  = DECERR;
        end
`endif
    end

    always_comb begin
        m_bvalid = 1'b0;
        m_bresp  = OKAY;
        if (w_state_q == W_RESP) begin
            for (int i = 0; i < NSLV; i++) begin
                if (w_sel_q[i]) begin
                    m_bvalid = m_bvalid | s_bvalid[i];
                    m_bresp  = m_bresp | s_bresp[i*2 +: 2];
                end
            end
        end
`ifdef XBAR_DECERR_EN
        if (w_state_q == W_ERR) begin
            m_bvalid = 1'b1;
            m_bresp  = DECERR;
        end
`endif
    end

    for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
        assign s_arvalid[gi] = (r_state_q == R_ADDR) && r_sel_q[gi];
        assign s_araddr[gi*ADDR_W +: ADDR_W] = s_arvalid[gi] ? ar_addr_q : '0;
        assign s_rready[gi]  = (r_state_q == R_DATA) && r_sel_q[gi] && m_rready;

        assign s_awvalid[gi] = (w_state_q == W_ADDR) && w_sel_q[gi] && !aw_flag_q;
        assign s_awaddr[gi*ADDR_W +: ADDR_W] = s_awvalid[gi] ? aw_addr_q : '0;
        assign s_wvalid[gi]  = (w_state_q == W_ADDR) && w_sel_q[gi] && !w_flag_q;
        assign s_wdata[gi*DATA_W +: DATA_W] = s_wvalid[gi] ? w_data_q : '0;
        assign s_wstrb[gi*STRB_W +: STRB_W] = s_wvalid[gi] ? w_strb_q : '0;
        assign s_bready[gi]  = (w_state_q == W_RESP) && w_sel_q[gi] && m_bready;
    end

    always_comb begin
        r_state_d = r_state_q;
        ar_addr_d = ar_addr_q;
        r_sel_d   = r_sel_q;
        r_done    = 1'b0;
        r_skip    = |(r_sel_q & SKIP_MASK);
        case (r_state_q)
            R_IDLE: begin
                if (m_arvalid && m_arready) begin
                    ar_addr_d = m_araddr;
                    r_sel_d   = ar_route;
                    r_state_d = R_ADDR;
`ifdef XBAR_DECERR_EN
                    if (ar_unmapped) r_state_d = R_ERR;
`endif
                end
            end
            R_ADDR: begin
                if (|(s_arready & r_sel_q)) r_state_d = R_DATA;
            end
            R_DATA: begin
                if (m_rvalid && m_rready) begin
                    r_done    = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
`ifdef XBAR_DECERR_EN
            R_ERR: begin
                if (m_rready) begin
                    r_done    = 1'b1;
                    r_skip    = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
`endif
            default: r_state_d = R_IDLE;
        endcase
    end

    // In W_IDLE the flags mean "beat captured"; in W_ADDR they mean "slave handshake done".
    always_comb begin
        w_state_d = w_state_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        w_sel_d   = w_sel_q;
        aw_flag_d = aw_flag_q;
        w_flag_d  = w_flag_q;
        w_done    = 1'b0;
        w_skip    = |(w_sel_q & SKIP_MASK);
`ifdef XBAR_DECERR_EN
        aw_err_d  = aw_err_q;
`endif
        case (w_state_q)
            W_IDLE: begin
                if (m_awvalid && m_awready) begin
                    aw_addr_d = m_awaddr;
                    w_sel_d   = aw_route;
                    aw_flag_d = 1'b1;
`ifdef XBAR_DECERR_EN
                    aw_err_d  = aw_unmapped;
`endif
                end
                if (m_wvalid && m_wready) begin
                    w_data_d = m_wdata;
                    w_strb_d = m_wstrb;
                    w_flag_d = 1'b1;
                end
                if (aw_flag_d && w_flag_d) begin
                    aw_flag_d = 1'b0;
                    w_flag_d  = 1'b0;
                    w_state_d = W_ADDR;
`ifdef XBAR_DECERR_EN
                    if (aw_err_d) w_state_d = W_ERR;
`endif
                end
            end
            W_ADDR: begin
                if (|(s_awready & s_awvalid)) aw_flag_d = 1'b1;
                if (|(s_wready & s_wvalid))   w_flag_d  = 1'b1;
                if (aw_flag_d && w_flag_d) begin
                    aw_flag_d = 1'b0;
                    w_flag_d  = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (m_bvalid && m_bready) begin
                    w_done    = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
`ifdef XBAR_DECERR_EN
            W_ERR: begin
                if (m_bready) begin
                    w_done    = 1'b1;
                    w_skip    = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
`endif
            default: w_state_d = W_IDLE;
        endcase
    end

    assign diff_skip_d = (r_done && r_skip) || (w_done && w_skip);
    assign diff_skip   = diff_skip_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q   <= R_IDLE;
            ar_addr_q   <= '0;
            r_sel_q     <= '0;
            w_state_q   <= W_IDLE;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            w_sel_q     <= '0;
            aw_flag_q   <= 1'b0;
            w_flag_q    <= 1'b0;
            diff_skip_q <= 1'b0;
`ifdef XBAR_DECERR_EN
            aw_err_q    <= 1'b0;
`endif
        end else begin
            r_state_q   <= r_state_d;
            ar_addr_q   <= ar_addr_d;
            r_sel_q     <= r_sel_d;
            w_state_q   <= w_state_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            w_sel_q     <= w_sel_d;
            aw_flag_q   <= aw_flag_d;
            w_flag_q    <= w_flag_d;
            diff_skip_q <= diff_skip_d;
`ifdef XBAR_DECERR_EN
            aw_err_q    <= aw_err_d;
`endif
        end
    end

endmodule
